// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: multi-cycle issue controller for the Q-format FPU.
// Accepts one vector command at a time. It drives the operand selects, the
// XMM read addresses and the accumulate control for each issue beat. It then
// waits out the fixed FPU latency and raises a single XMM write-back strobe.
module fpu_op_sequencer #(
  parameter int XREG_ADDR_W = 3,
  parameter int FPU_LAT     = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [XREG_ADDR_W-1:0] cmd_xd,
  input  logic [XREG_ADDR_W-1:0] cmd_xs,
  input  logic [XREG_ADDR_W-1:0] cmd_xt,
  output logic                   busy,
  output logic                   issue_valid,
  output logic [1:0]             src_a,
  output logic [1:0]             src_b,
  output logic [XREG_ADDR_W-1:0] xa_addr,
  output logic [XREG_ADDR_W-1:0] xb_addr,
  output logic                   acc_en,
  output logic                   wb_en,
  output logic [XREG_ADDR_W-1:0] wb_addr
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WB} state_t;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_NEG  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_DOT3 = 2'd3;

  localparam logic [1:0] SRC_GPR  = 2'd0;
  localparam logic [1:0] SRC_ONE  = 2'd1;
  localparam logic [1:0] SRC_XMM  = 2'd2;
  localparam logic [1:0] SRC_NXMM = 2'd3;

  // Remaining latency after the last beat; zero means write back immediately.
  localparam logic [3:0] LAT_LOAD = 4'(FPU_LAT - 1);

  state_t                 state, state_nxt;
  logic [1:0]             beat, beat_nxt;
  logic [3:0]             lat_cnt, lat_nxt;
  logic [1:0]             op;
  logic [XREG_ADDR_W-1:0] xd, xs, xt;
  logic                   accept;
  logic                   last_beat;

  assign accept    = (state == IDLE) && cmd_valid && !flush;
  assign last_beat = (op == OP_DOT3) ? (beat == 2'd2) : 1'b1;

  // Control state and counters; asynchronously cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      beat    <= 2'd0;
      lat_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      beat    <= beat_nxt;
      lat_cnt <= lat_nxt;
    end
  end

  // Command fields captured on accept; write-back index is held until WB.
  always_ff @(posedge clk) begin
    if (accept) begin
      op <= cmd_op;
      xd <= cmd_xd;
      xs <= cmd_xs;
      xt <= cmd_xt;
    end
  end

  // Next-state and counter sequencing; flush overrides everything.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    lat_nxt   = lat_cnt;
    if (flush) begin
      state_nxt = IDLE;
      beat_nxt  = 2'd0;
      lat_nxt   = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state_nxt = ISSUE;
            beat_nxt  = 2'd0;
          end
        end
        ISSUE: begin
          if (last_beat) begin
            beat_nxt  = 2'd0;
            lat_nxt   = LAT_LOAD;
            state_nxt = (LAT_LOAD == 4'd0) ? WB : DRAIN;
          end else begin
            beat_nxt = beat + 2'd1;
          end
        end
        DRAIN: begin
          lat_nxt = lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) state_nxt = WB;
        end
        WB:      state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Beat contents and strobes decoded from registered state only.
  always_comb begin
    cmd_ready   = (state == IDLE);
    busy        = (state != IDLE);
    issue_valid = 1'b0;
    src_a       = SRC_GPR;
    src_b       = SRC_GPR;
    xa_addr     = '0;
    xb_addr     = '0;
    acc_en      = 1'b0;
    wb_en       = 1'b0;
    wb_addr     = '0;
    case (state)
      ISSUE: begin
        issue_valid = 1'b1;
        case (op)
          OP_LOAD: begin
            src_a = SRC_GPR;
            src_b = SRC_ONE;
          end
          OP_NEG: begin
            src_a   = SRC_NXMM;
            src_b   = SRC_ONE;
            xa_addr = xs;
          end
          OP_MUL: begin
            src_a   = SRC_XMM;
            src_b   = SRC_XMM;
            xa_addr = xs;
            xb_addr = xt;
          end
          default: begin
            src_a   = SRC_XMM;
            src_b   = SRC_XMM;
            xa_addr = xs + XREG_ADDR_W'(beat);
            xb_addr = xt + XREG_ADDR_W'(beat);
            acc_en  = (beat != 2'd0);
          end
        endcase
      end
      WB: begin
        wb_en   = 1'b1;
        wb_addr = xd;
      end
      default: ;
    endcase
  end

endmodule
